// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access controller: one handshaked bus transfer per request,
// with lane steering, byte enables and load extension. Optional macro: MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int REG_LEN = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               we,
  input  logic [1:0]         size,
  input  logic               uns,
  input  logic [REG_LEN-1:0] addr,
  input  logic [REG_LEN-1:0] wdata,
  output logic [REG_LEN-1:0] rdata,
  output logic               done,
  output logic               busy,
  output logic               err,
  output logic [REG_LEN-1:0] bus_addr,
  output logic [REG_LEN-1:0] bus_wdata,
  output logic [3:0]         bus_be,
  output logic               bus_we,
  output logic               bus_req,
  input  logic               bus_ack,
  input  logic [REG_LEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               we_p0, uns_p0, err_p0, trap_in;
  logic [1:0]         size_p0, size_n;
  logic [REG_LEN-1:0] addr_p0, wdata_p0;
  logic [7:0]         cnt;

  function automatic logic [REG_LEN-1:0] align_addr(input logic [REG_LEN-1:0] a,
                                                    input logic [1:0] sz);
    case (sz)
      2'b01:   align_addr = {a[REG_LEN-1:1], 1'b0};
      2'b10:   align_addr = {a[REG_LEN-1:2], 2'b00};
      default: align_addr = a;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [REG_LEN-1:0] lane_wdata(input logic [REG_LEN-1:0] w,
                                                    input logic [1:0] sz);
    case (sz)
      2'b00:   lane_wdata = {(REG_LEN/8){w[7:0]}};
      2'b01:   lane_wdata = {(REG_LEN/16){w[15:0]}};
      default: lane_wdata = w;
    endcase
  endfunction

  function automatic logic [REG_LEN-1:0] load_ext(input logic [REG_LEN-1:0] word,
                                                  input logic [1:0] a,
                                                  input logic [1:0] sz,
                                                  input logic u);
    logic [REG_LEN-1:0] lane;
    lane = word >> {a, 3'b000};
    case (sz)
      2'b00:   load_ext = {{(REG_LEN-8){~u & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{(REG_LEN-16){~u & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  endfunction

  // Size 11 behaves exactly like a word access everywhere downstream.
  assign size_n = (size == 2'b11) ? 2'b10 : size;

`ifdef MISALIGN_TRAP_EN
  assign trap_in = ((size_n == 2'b01) && addr[0]) ||
                   ((size_n == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  // Stage p0: request capture in IDLE (data registers carry no reset)
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      we_p0    <= we;
      size_p0  <= size_n;
      uns_p0   <= uns;
      addr_p0  <= align_addr(addr, size_n);
      wdata_p0 <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_p0 <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == REQ && !bus_ack) cnt <= cnt + 8'd1;
      else                          cnt <= '0;
      if (state == IDLE && start)   err_p0 <= trap_in;
      else if (state == REQ)        err_p0 <= !bus_ack && (cnt == TO_LAST);
      if (state == REQ && bus_ack && !we_p0)
        rdata <= load_ext(bus_rdata, addr_p0[1:0], size_p0, uns_p0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = trap_in ? DONE : REQ;
      REQ:  if (bus_ack || cnt == TO_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus side is only driven while a transfer is outstanding.
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req && we_p0;
  assign bus_addr  = bus_req ? {addr_p0[REG_LEN-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? byte_en(addr_p0[1:0], size_p0) : 4'b0000;
  assign bus_wdata = bus_req ? lane_wdata(wdata_p0, size_p0) : '0;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign err       = done && err_p0;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access controller sitting directly downstream of the PC/address mux. It takes the selected address plus an access request from the control unit and runs one handshaked bus transaction to main memory, for instruction fetch, load or store. It generates byte enables, aligns store data, extracts and sign/zero-extends load data, and reports completion, misalignment and bus timeout back to the control unit.

## Interface
- `TIMEOUT`, 255: max cycles `bus_req` may wait for `bus_ack` before aborting; 8-bit counter, range 1..255.
- `clk` in 1: core clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: access request, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load/fetch.
- `size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `uns` in 1: load zero-extend (1) or sign-extend (0).
- `addr` in `REG_LEN`: byte address from the address mux.
- `wdata` in `REG_LEN`: store data, right-aligned.
- `rdata` out `REG_LEN`: extended load result, held until next completed load.
- `done` out 1: one-cycle pulse, access finished (success or error).
- `busy` out 1: high in any state but IDLE.
- `err` out 1: valid with `done`; 1 = misaligned or timeout.
- `bus_addr` out `REG_LEN`: word address (`addr` with bits [1:0] = 0).
- `bus_wdata` out `REG_LEN`: lane-shifted store data.
- `bus_be` out 4: byte enables.
- `bus_we` out 1: bus write strobe.
- `bus_req` out 1: request, held until `bus_ack` or timeout.
- `bus_ack` in 1: memory completes transfer this cycle; `bus_rdata` valid same cycle.
- `bus_rdata` in `REG_LEN`: raw 32-bit word from memory.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: `start`=1 latches `we`, `size`, `uns`, `addr`, `wdata` into internal registers; go REQ (or DONE with error if misaligned and trap enabled).
- REQ: drive `bus_req`=1, `bus_addr`, `bus_be`, `bus_we`, `bus_wdata` from latched values, stable whole state. Counter increments each cycle without ack.
- `bus_ack`=1 in REQ: for loads, select lane by addr[1:0], extend per size/uns, register into `rdata`; go DONE, `err`=0.
- Counter reaches `TIMEOUT` without ack: drop `bus_req`, go DONE, `err`=1, `rdata` unchanged.
- DONE: `done`=1 for one cycle, then IDLE. `start` in DONE ignored.
- Byte enables: byte 0001<<a[1:0]; half 0011<<(a[1]*2); word 1111.
- Store data: byte replicated to all four lanes; half replicated to both halves; word as-is.
- Load extend: byte bit 7, half bit 15, per `uns`.
- Misaligned: half with a[0]=1, word with a[1:0]!=0.
- `rst` in any state: IDLE immediately, `bus_req`=0, counter cleared; an in-flight transaction is abandoned with no `done`.

## Timing
- Reset values: `rdata`=0, `done`=0, `busy`=0, `err`=0, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0.
- `start` at edge N -> `bus_req` high from N+1.
- `bus_ack` in first REQ cycle (N+1) -> `done`+`rdata` visible N+2; minimum latency 2 cycles, +1 per wait cycle.
- `bus_ack` arriving the same cycle the counter hits `TIMEOUT`: ack wins, success.
- `bus_ack` outside REQ: ignored.
- `busy` high from N+1 through the DONE cycle.

## Configuration
- `MISALIGN_TRAP_EN` defined: misaligned request skips REQ, no bus activity, `done`=1 with `err`=1 one cycle after `start`.
- Not defined: misalignment ignored; low address bits forced to natural alignment (half clears a[0], word clears a[1:0]) and access proceeds normally, `err` only on timeout.

## Test plan
- Word load: `addr`=0x100, `bus_rdata`=0xDEADBEEF, ack on 1st REQ cycle -> `bus_be`=1111, `bus_addr`=0x100, `rdata`=0xDEADBEEF, `done` 2 cycles after `start`, `err`=0.
- Signed byte load: `addr`=0x103, size 00, uns 0, `bus_rdata`=0x80123456 -> `bus_be`=1000, `rdata`=0xFFFFFF80; uns 1 -> 0x00000080.
- Half store: `addr`=0x22, `wdata`=0x0000ABCD, ack after 3 waits -> `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `done` 5 cycles after `start`.
- Timeout: `TIMEOUT`=4, no ack -> `bus_req` high exactly 4 cycles, `done`+`err`=1, `rdata` unchanged.
- Misaligned word at 0x101: with `MISALIGN_TRAP_EN` -> no `bus_req`, `done`+`err` next cycle; without -> `bus_addr`=0x100, `bus_be`=1111, `err`=0.
- Reset mid-REQ after 2 wait cycles -> next cycle `bus_req`=0, `busy`=0, no `done`; new `start` then completes normally.
